// File: rtl/alu32_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu32_arbiter_if
// Purpose  : Requester-side request/response bundle for alu32_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface alu32_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic [4*N_REQ-1:0]  req_sel;
    logic [N_REQ-1:0]    rsp_valid;
    logic [N_REQ-1:0]    rsp_ready;
    logic [31:0]         rsp_data;
    logic                rsp_ovf;
    logic                rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu32_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one registered alu32.
// Revision : 1.0 - initial release
// ============================================================================
module alu32_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu32_arbiter_if.slave    bus,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [3:0]        alu_sel,
    input  logic [31:0]       alu_out,
    input  logic              alu_ovf,
    output logic              busy
);

    localparam int c_IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_CNT_W = $clog2(ALU_LAT + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   r_grant;
    logic [N_REQ-1:0]     r_rsp_valid;
    logic [31:0]          r_rsp_data;
    logic                 r_rsp_ovf;
    logic                 r_rsp_err;

    logic [31:0]          w_a_arr   [N_REQ];
    logic [31:0]          w_b_arr   [N_REQ];
    logic [3:0]           w_sel_arr [N_REQ];
    logic [c_IDX_W-1:0]   w_cand;
    logic [c_IDX_W-1:0]   w_win;
    logic                 w_any;
    logic                 w_legal;
    logic [N_REQ-1:0]     w_win_onehot;
    logic [N_REQ-1:0]     w_grant_onehot;
    logic [N_REQ-1:0]     w_req_ready;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_a_arr[g]   = bus.req_a[32*g +: 32];
        assign w_b_arr[g]   = bus.req_b[32*g +: 32];
        assign w_sel_arr[g] = bus.req_sel[4*g +: 4];
    end

    // First pending requester at or after last+1, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = c_IDX_W'((int'(r_last) + 1 + i) % N_REQ);
            if (!w_any && bus.req_valid[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_win_onehot   = N_REQ'(1) << w_win;
    assign w_grant_onehot = N_REQ'(1) << r_grant;
    assign w_legal        = (w_sel_arr[w_win] <= 4'd4);
    assign w_req_ready    = ((r_state == IDLE) && w_any) ? w_win_onehot : '0;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign bus.rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_last      <= c_IDX_W'(N_REQ - 1);
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_err   <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_sel     <= '0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win;
                        r_last  <= w_win;
                        busy    <= 1'b1;
                        if (w_legal) begin
                            alu_a   <= w_a_arr[w_win];
                            alu_b   <= w_b_arr[w_win];
                            alu_sel <= w_sel_arr[w_win];
                            r_cnt   <= '0;
                            r_state <= EXEC;
                        end else begin
                            // Illegal select never reaches the ALU.
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_ovf   <= 1'b0;
                            r_rsp_valid <= w_win_onehot;
                            r_state     <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == c_CNT_W'(ALU_LAT)) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_ovf   <= alu_ovf;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_grant_onehot;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[r_grant]) begin
                        r_rsp_valid <= '0;
                        busy        <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu32_arbiter
// Purpose  : Self-checking bench for alu32_arbiter with behavioural ALU/arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu32_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = N - 1;

    alu32_arbiter_if #(.N_REQ(N)) bus1 ();
    alu32_arbiter_if #(.N_REQ(N)) bus3 ();

    logic [31:0] alu_a1, alu_b1, alu_out1, alu_a3, alu_b3, alu_out3;
    logic [3:0]  alu_sel1, alu_sel3;
    logic        alu_ovf1, alu_ovf3, busy1, busy3;

    alu32_arbiter #(.N_REQ(N), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_out(alu_out1), .alu_ovf(alu_ovf1), .busy(busy1)
    );

    alu32_arbiter #(.N_REQ(N), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
        .alu_out(alu_out3), .alu_ovf(alu_ovf3), .busy(busy3)
    );

    // Behavioural ALU: {overflow, result}
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        logic [31:0] r;
        logic        v;
        r = '0;
        v = 1'b0;
        case (s)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd4: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            default: ;
        endcase
        return {v, r};
    endfunction

    logic [32:0] p1;
    logic [32:0] p3 [3];
    always @(posedge clk) begin
        p1    <= alu_ref(alu_a1, alu_b1, alu_sel1);
        p3[0] <= alu_ref(alu_a3, alu_b3, alu_sel3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign {alu_ovf1, alu_out1} = p1;
    assign {alu_ovf3, alu_out3} = p3[2];

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus1.req_valid = '0; bus1.rsp_ready = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.req_sel = '0;
        bus3.req_valid = '0; bus3.rsp_ready = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_sel = '0;
    endtask

    task automatic drive_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
        bus1.req_a[32*i +: 32] = a;
        bus1.req_b[32*i +: 32] = b;
        bus1.req_sel[4*i +: 4] = s;
    endtask

    task automatic wait_rsp1(output int k);
        k = 1;
        while (bus1.rsp_valid == '0 && k < 50) begin
            tick();
            k++;
        end
        if (bus1.rsp_valid == '0) k = -1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus1.req_ready, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf, bus1.rsp_err, alu_a1, alu_b1, alu_sel1, busy1} !== '0)
            begin n_fail++; $display("FAIL reset_outputs: rsp_valid=%b data=%h alu_a=%h busy=%b expected all zero", bus1.rsp_valid, bus1.rsp_data, alu_a1, busy1); end
        n_checks++;
        if ({bus3.req_ready, bus3.rsp_valid, bus3.rsp_data, alu_a3, alu_sel3, busy3} !== '0)
            begin n_fail++; $display("FAIL reset_outputs_lat3: rsp_valid=%b busy=%b expected zero", bus3.rsp_valid, busy3); end
        rst_n = 1'b1;
        m_last = N - 1;
        tick();
        n_checks++;
        if (busy1 !== 1'b0 || bus1.req_ready !== '0)
            begin n_fail++; $display("FAIL reset_idle: busy=%b req_ready=%b expected 0/0000", busy1, bus1.req_ready); end
    endtask

    task automatic test_single();
        int k;
        int w;
        idle_inputs();
        drive_req(0, 32'h0000_00F0, 32'h0000_000F, 4'b0011);
        bus1.req_valid = 4'b0001;
        #1;
        w = rr_pick(4'b0001, m_last);
        n_checks++;
        if (bus1.req_ready !== (N'(1) << w))
            begin n_fail++; $display("FAIL single_grant: req_ready=%b expected %b", bus1.req_ready, N'(1) << w); end
        tick();
        bus1.req_valid = '0;
        m_last = w;
        n_checks++;
        if (alu_a1 !== 32'h0000_00F0 || alu_b1 !== 32'h0000_000F || alu_sel1 !== 4'b0011)
            begin n_fail++; $display("FAIL single_alu_in: a=%h b=%h sel=%b expected 000000f0/0000000f/0011", alu_a1, alu_b1, alu_sel1); end
        wait_rsp1(k);
        n_checks++;
        if (k != 3) begin n_fail++; $display("FAIL single_latency: %0d cycles expected 3", k); end
        n_checks++;
        if (bus1.rsp_valid !== 4'b0001 || bus1.rsp_data !== 32'h0000_00FF || bus1.rsp_ovf !== 1'b0 || bus1.rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL single_rsp: valid=%b data=%h ovf=%b err=%b expected 0001/000000ff/0/0", bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf, bus1.rsp_err); end
        bus1.rsp_ready = 4'b0001;
        tick();
        bus1.rsp_ready = '0;
        n_checks++;
        if (bus1.rsp_valid !== '0 || busy1 !== 1'b0)
            begin n_fail++; $display("FAIL single_release: rsp_valid=%b busy=%b expected 0000/0", bus1.rsp_valid, busy1); end
    endtask

    task automatic test_overflow();
        int k;
        int w;
        idle_inputs();
        drive_req(1, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0011);
        bus1.req_valid = 4'b0010;
        bus1.rsp_ready = 4'b0010;
        #1;
        w = rr_pick(4'b0010, m_last);
        tick();
        bus1.req_valid = '0;
        m_last = w;
        wait_rsp1(k);
        n_checks++;
        if (k != 3 || bus1.rsp_valid !== 4'b0010 || bus1.rsp_data !== 32'h8000_0000 || bus1.rsp_ovf !== 1'b1)
            begin n_fail++; $display("FAIL overflow: k=%0d valid=%b data=%h ovf=%b expected 3/0010/80000000/1", k, bus1.rsp_valid, bus1.rsp_data, bus1.rsp_ovf); end
        tick();
        bus1.rsp_ready = '0;
    endtask

    task automatic test_random();
        logic [31:0] a [N];
        logic [31:0] b [N];
        logic [3:0]  s [N];
        logic [N-1:0] v;
        logic [32:0] ex;
        logic        legal;
        int w, k, dly;
        for (int it = 0; it < 24; it++) begin
            idle_inputs();
            for (int i = 0; i < N; i++) begin
                a[i] = $urandom;
                b[i] = $urandom;
                s[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
                drive_req(i, a[i], b[i], s[i]);
            end
            v = N'($urandom_range(1, (1 << N) - 1));
            bus1.req_valid = v;
            #1;
            w = rr_pick(v, m_last);
            n_checks++;
            if (bus1.req_ready !== (N'(1) << w))
                begin n_fail++; $display("FAIL rand_grant[%0d]: req_ready=%b expected %b", it, bus1.req_ready, N'(1) << w); end
            tick();
            bus1.req_valid = '0;
            m_last = w;
            dly = $urandom_range(0, 3);
            if (dly == 0) bus1.rsp_ready = '1;
            legal = (s[w] <= 4'd4);
            ex = legal ? alu_ref(a[w], b[w], s[w]) : 33'd0;
            wait_rsp1(k);
            n_checks++;
            if (k != (legal ? 3 : 1))
                begin n_fail++; $display("FAIL rand_latency[%0d]: %0d cycles expected %0d", it, k, legal ? 3 : 1); end
            repeat (dly) tick();
            n_checks++;
            if (bus1.rsp_valid !== (N'(1) << w) || bus1.rsp_err !== !legal || {bus1.rsp_ovf, bus1.rsp_data} !== ex)
                begin n_fail++; $display("FAIL rand_rsp[%0d]: valid=%b err=%b ovf/data=%h expected %b/%b/%h", it, bus1.rsp_valid, bus1.rsp_err, {bus1.rsp_ovf, bus1.rsp_data}, N'(1) << w, !legal, ex); end
            bus1.rsp_ready[w] = 1'b1;
            tick();
            bus1.rsp_ready = '0;
            n_checks++;
            if (busy1 !== 1'b0 || bus1.rsp_valid !== '0)
                begin n_fail++; $display("FAIL rand_release[%0d]: busy=%b rsp_valid=%b expected 0/0000", it, busy1, bus1.rsp_valid); end
        end
    endtask

    task automatic test_round_robin();
        int grants, cyc, last_cyc, ex;
        idle_inputs();
        for (int i = 0; i < N; i++) drive_req(i, 32'(i + 1), 32'h10, 4'd3);
        bus1.req_valid = '1;
        bus1.rsp_ready = '1;
        grants = 0; cyc = 0; last_cyc = 0;
        while (grants < 5 && cyc < 60) begin
            #1;
            n_checks++;
            if ($countones(bus1.req_ready) > 1)
                begin n_fail++; $display("FAIL rr_onehot: req_ready=%b expected at most one bit", bus1.req_ready); end
            if (bus1.req_ready != '0) begin
                ex = (m_last + 1) % N;
                n_checks++;
                if (bus1.req_ready !== (N'(1) << ex))
                    begin n_fail++; $display("FAIL rr_order[%0d]: req_ready=%b expected %b", grants, bus1.req_ready, N'(1) << ex); end
                if (grants > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 4)
                        begin n_fail++; $display("FAIL rr_spacing[%0d]: %0d cycles expected 4", grants, cyc - last_cyc); end
                end
                last_cyc = cyc;
                m_last = ex;
                grants++;
            end
            tick();
            cyc++;
            if (grants == 5) bus1.req_valid = '0;
        end
        n_checks++;
        if (grants != 5) begin n_fail++; $display("FAIL rr_timeout: %0d grants expected 5", grants); end
        for (int i = 0; i < 20 && busy1; i++) tick();
        bus1.rsp_ready = '0;
    endtask

    task automatic test_illegal_backpressure();
        logic [3:0] prev_sel;
        idle_inputs();
        drive_req(2, 32'h1234_5678, 32'h0000_5678, 4'b1010);
        bus1.req_valid = 4'b0100;
        prev_sel = alu_sel1;
        #1;
        n_checks++;
        if (bus1.req_ready !== 4'b0100)
            begin n_fail++; $display("FAIL illegal_grant: req_ready=%b expected 0100", bus1.req_ready); end
        tick();
        m_last = 2;
        bus1.req_valid = 4'b1011;
        bus1.rsp_ready = 4'b0010;
        #1;
        n_checks++;
        if (bus1.rsp_valid !== 4'b0100 || bus1.rsp_err !== 1'b1 || bus1.rsp_data !== '0 || bus1.rsp_ovf !== 1'b0 || alu_sel1 !== prev_sel)
            begin n_fail++; $display("FAIL illegal_rsp: valid=%b err=%b data=%h alu_sel=%b expected 0100/1/0/%b", bus1.rsp_valid, bus1.rsp_err, bus1.rsp_data, alu_sel1, prev_sel); end
        for (int c = 0; c < 5; c++) begin
            tick();
            #1;
            n_checks++;
            if (bus1.rsp_valid !== 4'b0100 || bus1.rsp_err !== 1'b1 || bus1.rsp_data !== '0 || bus1.req_ready !== '0)
                begin n_fail++; $display("FAIL illegal_hold[%0d]: valid=%b err=%b req_ready=%b expected 0100/1/0000", c, bus1.rsp_valid, bus1.rsp_err, bus1.req_ready); end
        end
        bus1.req_valid = '0;
        bus1.rsp_ready = 4'b0100;
        tick();
        bus1.rsp_ready = '0;
        n_checks++;
        if (bus1.rsp_valid !== '0 || busy1 !== 1'b0)
            begin n_fail++; $display("FAIL illegal_release: valid=%b busy=%b expected 0000/0", bus1.rsp_valid, busy1); end
    endtask

    task automatic test_reset_mid_exec();
        int k;
        logic seen;
        idle_inputs();
        drive_req(3, 32'h5, 32'h6, 4'd3);
        bus1.req_valid = 4'b1000;
        tick();
        bus1.req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy1, alu_a1, alu_b1, alu_sel1, bus1.rsp_valid, bus1.req_ready, bus1.rsp_data} !== '0)
            begin n_fail++; $display("FAIL async_reset: busy=%b alu_a=%h rsp_valid=%b expected zero", busy1, alu_a1, bus1.rsp_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_last = N - 1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (bus1.rsp_valid != '0 || busy1) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_abort: response/busy seen=%b expected 0", seen); end
        drive_req(1, 32'hA, 32'h3, 4'd4);
        bus1.req_valid = 4'b0010;
        #1;
        n_checks++;
        if (bus1.req_ready !== (N'(1) << rr_pick(4'b0010, m_last)))
            begin n_fail++; $display("FAIL post_reset_grant: req_ready=%b expected 0010", bus1.req_ready); end
        tick();
        bus1.req_valid = '0;
        m_last = 1;
        wait_rsp1(k);
        n_checks++;
        if (k != 3 || bus1.rsp_valid !== 4'b0010 || bus1.rsp_data !== 32'h7)
            begin n_fail++; $display("FAIL post_reset_rsp: k=%0d valid=%b data=%h expected 3/0010/00000007", k, bus1.rsp_valid, bus1.rsp_data); end
        bus1.rsp_ready = 4'b0010;
        tick();
        bus1.rsp_ready = '0;
    endtask

    task automatic test_param_sweep();
        int k;
        idle_inputs();
        bus3.req_a[32*3 +: 32] = 32'hFFFF_0000;
        bus3.req_b[32*3 +: 32] = 32'h0F0F_0F0F;
        bus3.req_sel[4*3 +: 4] = 4'd0;
        bus3.req_valid = 4'b1000;
        #1;
        n_checks++;
        if (bus3.req_ready !== 4'b1000)
            begin n_fail++; $display("FAIL lat3_grant: req_ready=%b expected 1000", bus3.req_ready); end
        tick();
        bus3.req_valid = '0;
        k = 1;
        while (bus3.rsp_valid == '0 && k < 50) begin tick(); k++; end
        n_checks++;
        if (k != 5) begin n_fail++; $display("FAIL lat3_latency: %0d cycles expected 5", k); end
        n_checks++;
        if (bus3.rsp_valid !== 4'b1000 || {bus3.rsp_ovf, bus3.rsp_data} !== alu_ref(32'hFFFF_0000, 32'h0F0F_0F0F, 4'd0) || bus3.rsp_err !== 1'b0)
            begin n_fail++; $display("FAIL lat3_rsp: valid=%b data=%h err=%b expected 1000/0f0f0000/0", bus3.rsp_valid, bus3.rsp_data, bus3.rsp_err); end
        bus3.rsp_ready = 4'b1000;
        tick();
        bus3.rsp_ready = '0;
        n_checks++;
        if (busy3 !== 1'b0) begin n_fail++; $display("FAIL lat3_release: busy=%b expected 0", busy3); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_overflow();
        test_random();
        test_round_robin();
        test_illegal_backpressure();
        test_reset_mid_exec();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
